// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every N_IN-bit vector, compares two implementations' responses.
// Latency: start edge to done = 2^N_IN*(SETTLE+1)+1 cycles; each vector held SETTLE+1 cycles.
// Backpressure: none; start ignored while sweeping, abort stops a sweep and freezes results.
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    output logic [N_IN-1:0]   o_vec_out,
    output logic              o_vec_valid,
    input  logic [N_OUT-1:0]  i_resp_a,
    input  logic [N_OUT-1:0]  i_resp_b,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [N_IN:0]     o_mismatch_cnt,
    output logic [N_IN-1:0]   o_first_err_vec,
    output logic              o_first_err_vld
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_IN-1:0]   r_vec;
    logic [3:0]        r_settle;
    logic [N_IN:0]     r_cnt;
    logic [N_IN-1:0]   r_first_vec;
    logic              r_first_vld;
    logic              r_pass;

    logic              w_apply;
    logic              w_accept;
    logic              w_run;
    logic              w_sample;
    logic              w_last;
    logic              w_mis;

    // Abort has priority over sampling so the results freeze exactly where the sweep stopped.
    assign w_apply  = (r_state == S_APPLY);
    assign w_accept = i_start && !w_apply;
    assign w_run    = w_apply && !i_abort;
    assign w_sample = w_run && (r_settle == SETTLE_L);
    assign w_last   = &r_vec;
    assign w_mis    = (i_resp_a != i_resp_b);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE/DONE re-arm on start, APPLY ends on last sample or abort.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_APPLY;
            S_APPLY: begin
                if (i_abort)                 w_state_nxt = S_IDLE;
                else if (w_sample && w_last) w_state_nxt = S_DONE;
            end
            S_DONE:  if (i_start) w_state_nxt = S_APPLY;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Vector walk, settle timing and result capture; everything holds when not running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vec       <= '0;
            r_settle    <= '0;
            r_cnt       <= '0;
            r_first_vec <= '0;
            r_first_vld <= 1'b0;
            r_pass      <= 1'b0;
        end else if (w_accept) begin
            r_vec       <= '0;
            r_settle    <= '0;
            r_cnt       <= '0;
            r_first_vec <= '0;
            r_first_vld <= 1'b0;
            r_pass      <= 1'b0;
        end else if (w_sample) begin
            r_settle <= '0;
            if (w_mis) begin
                r_cnt <= r_cnt + 1'b1;
                if (!r_first_vld) begin
                    r_first_vec <= r_vec;
                    r_first_vld <= 1'b1;
                end
            end
            // The final vector stays on the bus; the verdict includes its own sample.
            if (w_last) begin
                r_pass <= (r_cnt == '0) && !w_mis;
            end else begin
                r_vec <= r_vec + 1'b1;
            end
        end else if (w_run) begin
            r_settle <= r_settle + 4'd1;
        end
    end

    assign o_vec_out       = r_vec;
    assign o_vec_valid     = w_apply;
    assign o_busy          = w_apply;
    assign o_done          = (r_state == S_DONE);
    assign o_pass          = r_pass;
    assign o_mismatch_cnt  = r_cnt;
    assign o_first_err_vec = r_first_vec;
    assign o_first_err_vld = r_first_vld;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: random fault masks on B, expected results from a popcount/lowest-bit model.
// Latency: checks start-to-done cycle count and per-cycle vector sequence.
// Backpressure: exercises ignored starts, abort, abort+start and mid-sweep reset.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic start4 = 1'b0;
    logic abort4 = 1'b0;

    logic [2:0] vec;
    logic       vld, busy, done, pass, fvld;
    logic [3:0] cnt;
    logic [2:0] fvec;
    logic       ra, rb;

    logic [3:0] vec4;
    logic       vld4, busy4, done4, pass4, fvld4;
    logic [4:0] cnt4;
    logic [3:0] fvec4;
    logic [1:0] ra4, rb4;

    logic [7:0]  mask  = 8'h00;
    logic [15:0] mask4 = 16'h0000;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // A is 3-input XOR; B is the same function with chosen vectors inverted.
    assign ra  = ^vec;
    assign rb  = ra ^ mask[vec];
    assign ra4 = {^vec4, &vec4};
    assign rb4 = ra4 ^ {1'b0, mask4[vec4]};

    truth_table_sweeper #(.N_IN(3), .N_OUT(1), .SETTLE(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .o_vec_out(vec), .o_vec_valid(vld), .i_resp_a(ra), .i_resp_b(rb),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_mismatch_cnt(cnt),
        .o_first_err_vec(fvec), .o_first_err_vld(fvld)
    );

    truth_table_sweeper #(.N_IN(4), .N_OUT(2), .SETTLE(0)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_abort(abort4),
        .o_vec_out(vec4), .o_vec_valid(vld4), .i_resp_a(ra4), .i_resp_b(rb4),
        .o_busy(busy4), .o_done(done4), .o_pass(pass4), .o_mismatch_cnt(cnt4),
        .o_first_err_vec(fvec4), .o_first_err_vld(fvld4)
    );

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({busy, vld, done, pass, fvld, vec, cnt, fvec} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %0h expected 0", {busy, vld, done, pass, fvld, vec, cnt, fvec});
        end
        total++;
        if ({busy4, vld4, done4, pass4, fvld4, vec4, cnt4, fvec4} !== 18'd0) begin
            bad++;
            $display("FAIL reset_outputs4: got %0h expected 0", {busy4, vld4, done4, pass4, fvld4, vec4, cnt4, fvec4});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset: got %0b expected 00", {busy, done});
        end
    endtask

    // Full sweep on the 3-bit engine; extra=1 sprinkles ignored start pulses while busy.
    task automatic test_sweep(input logic [7:0] m, input bit extra);
        int lat;
        int exp_cnt;
        int exp_first;
        mask = m;
        exp_cnt = $countones(m);
        exp_first = 0;
        for (int i = 7; i >= 0; i--) if (m[i]) exp_first = i;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin
            total++;
            if (busy !== 1'b1 || vld !== 1'b1 || vec !== 3'((lat - 1) / 2)) begin
                bad++;
                $display("FAIL sweep_cycle%0d: got busy=%b vld=%b vec=%0d expected 1 1 %0d",
                         lat, busy, vld, vec, (lat - 1) / 2);
            end
            start = (extra && lat < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        total++;
        if (lat != 17) begin
            bad++;
            $display("FAIL sweep_latency: got %0d expected 17", lat);
        end
        total++;
        if (cnt !== 4'(exp_cnt)) begin
            bad++;
            $display("FAIL sweep_cnt mask=%0h: got %0d expected %0d", m, cnt, exp_cnt);
        end
        total++;
        if (pass !== (exp_cnt == 0)) begin
            bad++;
            $display("FAIL sweep_pass mask=%0h: got %b expected %b", m, pass, exp_cnt == 0);
        end
        total++;
        if (fvld !== (exp_cnt != 0) || fvec !== 3'(exp_first)) begin
            bad++;
            $display("FAIL sweep_first mask=%0h: got vld=%b vec=%0d expected %b %0d",
                     m, fvld, fvec, exp_cnt != 0, exp_first);
        end
        total++;
        if (busy !== 1'b0 || vld !== 1'b0 || vec !== 3'd7) begin
            bad++;
            $display("FAIL sweep_end: got busy=%b vld=%b vec=%0d expected 0 0 7", busy, vld, vec);
        end
        repeat (3) @(negedge clk);
        total++;
        if (done !== 1'b1 || cnt !== 4'(exp_cnt) || vec !== 3'd7) begin
            bad++;
            $display("FAIL sweep_hold: got done=%b cnt=%0d vec=%0d expected 1 %0d 7", done, cnt, vec, exp_cnt);
        end
    endtask

    // Abort during the 5th APPLY cycle; vectors 0 and 1 have been sampled by then.
    task automatic test_abort(input logic [7:0] m, input bit with_start);
        int exp_cnt;
        int exp_first;
        mask = m;
        exp_cnt = $countones(m[1:0]);
        exp_first = (m[0]) ? 0 : 1;
        if (exp_cnt == 0) exp_first = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        start = with_start;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || vld !== 1'b0 || done !== 1'b0 || vec !== 3'd2) begin
            bad++;
            $display("FAIL abort_state: got busy=%b vld=%b done=%b vec=%0d expected 0 0 0 2", busy, vld, done, vec);
        end
        total++;
        if (cnt !== 4'(exp_cnt) || fvld !== (exp_cnt != 0) || fvec !== 3'(exp_first)) begin
            bad++;
            $display("FAIL abort_counts: got cnt=%0d vld=%b vec=%0d expected %0d %b %0d",
                     cnt, fvld, fvec, exp_cnt, exp_cnt != 0, exp_first);
        end
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || vec !== 3'd2 || cnt !== 4'(exp_cnt)) begin
            bad++;
            $display("FAIL abort_idle_hold: got busy=%b done=%b vec=%0d cnt=%0d expected 0 0 2 %0d",
                     busy, done, vec, cnt, exp_cnt);
        end
    endtask

    task automatic test_mid_reset();
        mask = 8'hFF;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat ($urandom_range(4, 12)) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, vld, done, pass, fvld, vec, cnt, fvec} !== 15'd0) begin
            bad++;
            $display("FAIL mid_reset: got %0h expected 0", {busy, vld, done, pass, fvld, vec, cnt, fvec});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // 4-bit engine, no settle: one vector per cycle, two-bit responses.
    task automatic test_wide(input logic [15:0] m);
        int lat;
        int exp_cnt;
        int exp_first;
        mask4 = m;
        exp_cnt = $countones(m);
        exp_first = 0;
        for (int i = 15; i >= 0; i--) if (m[i]) exp_first = i;
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        lat = 1;
        while (done4 !== 1'b1 && lat < 60) begin
            total++;
            if (busy4 !== 1'b1 || vec4 !== 4'(lat - 1)) begin
                bad++;
                $display("FAIL wide_cycle%0d: got busy=%b vec=%0d expected 1 %0d", lat, busy4, vec4, lat - 1);
            end
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != 17) begin
            bad++;
            $display("FAIL wide_latency: got %0d expected 17", lat);
        end
        total++;
        if (cnt4 !== 5'(exp_cnt) || pass4 !== (exp_cnt == 0) || fvld4 !== (exp_cnt != 0) || fvec4 !== 4'(exp_first)) begin
            bad++;
            $display("FAIL wide_result mask=%0h: got cnt=%0d pass=%b vld=%b first=%0d expected %0d %b %b %0d",
                     m, cnt4, pass4, fvld4, fvec4, exp_cnt, exp_cnt == 0, exp_cnt != 0, exp_first);
        end
    endtask

    initial begin
        test_reset();
        test_sweep(8'h00, 1'b0);
        test_sweep(8'h20, 1'b0);
        test_sweep(8'h48, 1'b0);
        for (int k = 0; k < 4; k++) test_sweep(8'($urandom), 1'b1);
        test_abort(8'($urandom), 1'b0);
        test_abort(8'($urandom), 1'b1);
        test_sweep(8'($urandom), 1'b0);
        test_mid_reset();
        test_sweep(8'h81, 1'b1);
        test_wide(16'h0000);
        test_wide(16'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
